// File: rtl/functional_unit.sv
// functional_unit: single-cycle ALU / address generator with registered wakeup broadcasts
module functional_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_enable,
    input  logic [3:0]  ALUControl,
    input  logic        ALUSrc,
    input  logic        is_for_lsq,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_value,
    input  logic [31:0] rs2_value,
    input  logic [5:0]  tag_to_output,
    input  logic [5:0]  rob_index,
    output logic        is_available,
    output logic        wakeup_active,
    output logic [5:0]  wakeup_rob_index,
    output logic [5:0]  wakeup_tag,
    output logic [31:0] wakeup_value,
    output logic        lsq_wakeup_active,
    output logic [5:0]  lsq_wakeup_rob_index,
    output logic [31:0] lsq_wakeup_value
);
    logic [31:0] b, alu, res;
    logic        reg_issue, lsq_issue;

    always_comb begin
        b = ALUSrc ? imm : rs2_value;
        alu = '0;
        case (ALUControl)
            4'b0000: alu = rs1_value & b;
            4'b0001: alu = rs1_value | b;
            4'b0010: alu = rs1_value + b;
            4'b0011: alu = rs1_value ^ b;
            4'b0110: alu = rs1_value - b;
            4'b0100: alu = rs1_value << b[4:0];
            4'b0101: alu = rs1_value >> b[4:0];
            4'b1000: alu = $signed(rs1_value) >>> b[4:0];
            4'b0111: alu = {31'b0, $signed(rs1_value) < $signed(b)};
            4'b1001: alu = {31'b0, rs1_value < b};
            4'b1010: alu = b;
            default: alu = '0;
        endcase
        // x0 never receives a nonzero value
        res = is_for_lsq ? rs1_value + b : (tag_to_output == '0 ? '0 : alu);
        reg_issue = write_enable && !is_for_lsq;
        lsq_issue = write_enable && is_for_lsq;
    end

    assign is_available = reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wakeup_active        <= 1'b0;
            wakeup_rob_index     <= '0;
            wakeup_tag           <= '0;
            wakeup_value         <= '0;
            lsq_wakeup_active    <= 1'b0;
            lsq_wakeup_rob_index <= '0;
            lsq_wakeup_value     <= '0;
        end else begin
            wakeup_active        <= reg_issue;
            wakeup_rob_index     <= reg_issue ? rob_index : '0;
            wakeup_tag           <= reg_issue ? tag_to_output : '0;
            wakeup_value         <= reg_issue ? res : '0;
            lsq_wakeup_active    <= lsq_issue;
            lsq_wakeup_rob_index <= lsq_issue ? rob_index : '0;
            lsq_wakeup_value     <= lsq_issue ? res : '0;
        end
    end
endmodule

// File: tb/tb_functional_unit.sv
// tb_functional_unit: directed vector table, corner sequences and randomized model check
module tb_functional_unit;
    logic        clk = 0;
    logic        reset = 0;
    logic        write_enable = 0;
    logic [3:0]  ALUControl = '0;
    logic        ALUSrc = 0;
    logic        is_for_lsq = 0;
    logic [31:0] imm = '0, rs1_value = '0, rs2_value = '0;
    logic [5:0]  tag_to_output = '0, rob_index = '0;
    logic        is_available, wakeup_active, lsq_wakeup_active;
    logic [5:0]  wakeup_rob_index, wakeup_tag, lsq_wakeup_rob_index;
    logic [31:0] wakeup_value, lsq_wakeup_value;
    int tests = 0, failed = 0;

    functional_unit dut (
        .clk(clk), .reset(reset), .write_enable(write_enable), .ALUControl(ALUControl),
        .ALUSrc(ALUSrc), .is_for_lsq(is_for_lsq), .imm(imm), .rs1_value(rs1_value),
        .rs2_value(rs2_value), .tag_to_output(tag_to_output), .rob_index(rob_index),
        .is_available(is_available), .wakeup_active(wakeup_active),
        .wakeup_rob_index(wakeup_rob_index), .wakeup_tag(wakeup_tag),
        .wakeup_value(wakeup_value), .lsq_wakeup_active(lsq_wakeup_active),
        .lsq_wakeup_rob_index(lsq_wakeup_rob_index), .lsq_wakeup_value(lsq_wakeup_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  ctl;
        logic        src, lsq;
        logic [31:0] imm, rs1, rs2;
        logic [5:0]  tag, rob;
        logic [31:0] val;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(string n, logic [3:0] c, logic s, logic l, logic [31:0] i,
                                logic [31:0] a, logic [31:0] r2, logic [5:0] t, logic [5:0] rb,
                                logic [31:0] v);
        vec_t x;
        x.name = n; x.ctl = c; x.src = s; x.lsq = l; x.imm = i;
        x.rs1 = a; x.rs2 = r2; x.tag = t; x.rob = rb; x.val = v;
        return x;
    endfunction

    // Expected output bundle in the same field order as the DUT snapshot below
    function automatic logic [84:0] pack(logic avail, logic act, logic lsq, logic [5:0] tag,
                                         logic [5:0] rob, logic [31:0] val);
        if (!act) return {avail, 84'b0};
        if (lsq) return {avail, 1'b0, 6'd0, 6'd0, 32'd0, 1'b1, rob, val};
        return {avail, 1'b1, rob, tag, val, 1'b0, 6'd0, 32'd0};
    endfunction

    function automatic logic [31:0] ref_alu(logic [3:0] c, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        int sh;
        sh = int'(b % 32);
        r = a;
        case (c)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd3: return a ^ b;
            4'd6: return a - b;
            4'd4: begin for (int i = 0; i < sh; i++) r = r * 2; return r; end
            4'd5: begin for (int i = 0; i < sh; i++) r = r / 2; return r; end
            4'd8: begin for (int i = 0; i < sh; i++) r = (r / 2) | (a & 32'h8000_0000); return r; end
            4'd7: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(string name, logic [84:0] exp);
        logic [84:0] act;
        act = {is_available, wakeup_active, wakeup_rob_index, wakeup_tag, wakeup_value,
               lsq_wakeup_active, lsq_wakeup_rob_index, lsq_wakeup_value};
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(logic we, logic [3:0] c, logic s, logic l, logic [31:0] i,
                         logic [31:0] a, logic [31:0] r2, logic [5:0] t, logic [5:0] rb);
        write_enable = we; ALUControl = c; ALUSrc = s; is_for_lsq = l;
        imm = i; rs1_value = a; rs2_value = r2; tag_to_output = t; rob_index = rb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] v, bb;
        logic we, l, s;
        logic [3:0] c;
        logic [5:0] t, rb;
        logic [31:0] i, a, r2;

        tbl.push_back(mk("add",   4'h2, 0, 0, 0, 5, 7, 12, 3, 12));
        tbl.push_back(mk("addi",  4'h2, 1, 0, 32'hFFFF_FFFF, 0, 0, 5, 4, 32'hFFFF_FFFF));
        tbl.push_back(mk("sub",   4'h6, 0, 0, 0, 3, 5, 6, 5, 32'hFFFF_FFFE));
        tbl.push_back(mk("slt",   4'h7, 0, 0, 0, 32'hFFFF_FFFF, 1, 7, 6, 1));
        tbl.push_back(mk("sltu",  4'h9, 0, 0, 0, 32'hFFFF_FFFF, 1, 8, 7, 0));
        tbl.push_back(mk("sra",   4'h8, 0, 0, 0, 32'h8000_0000, 32'h21, 9, 8, 32'hC000_0000));
        tbl.push_back(mk("srl",   4'h5, 0, 0, 0, 32'h8000_0000, 32'h21, 10, 9, 32'h4000_0000));
        tbl.push_back(mk("lsq",   4'h6, 1, 1, 8, 32'h100, 0, 33, 9, 32'h108));
        tbl.push_back(mk("x0",    4'h2, 0, 0, 0, 5, 7, 0, 10, 0));
        tbl.push_back(mk("and",   4'h0, 0, 0, 0, 32'hF0F0_FF00, 32'h0FF0_F0F0, 11, 11, 32'h00F0_F000));
        tbl.push_back(mk("or",    4'h1, 0, 0, 0, 32'hF0F0_FF00, 32'h0FF0_F0F0, 12, 12, 32'hFFF0_FFF0));
        tbl.push_back(mk("xor",   4'h3, 0, 0, 0, 32'hF0F0_FF00, 32'h0FF0_F0F0, 13, 13, 32'hFF00_0FF0));
        tbl.push_back(mk("sll",   4'h4, 1, 0, 4, 32'h0000_1234, 0, 14, 14, 32'h0001_2340));
        tbl.push_back(mk("lui",   4'hA, 1, 0, 32'h1234_5000, 32'hDEAD, 0, 15, 15, 32'h1234_5000));
        tbl.push_back(mk("undef", 4'hF, 0, 0, 0, 32'h55, 32'h66, 16, 16, 0));

        #3;
        check("reset_state", pack(0, 0, 0, 0, 0, 0));
        drive(1, 4'h2, 0, 0, 0, 1, 1, 1, 1);
        tick();
        check("issue_in_reset", pack(0, 0, 0, 0, 0, 0));
        reset = 1;
        tick();
        check("first_edge_after_reset", pack(1, 1, 0, 1, 1, 2));

        foreach (tbl[k]) begin
            drive(1, tbl[k].ctl, tbl[k].src, tbl[k].lsq, tbl[k].imm, tbl[k].rs1,
                  tbl[k].rs2, tbl[k].tag, tbl[k].rob);
            tick();
            check(tbl[k].name, pack(1, 1, tbl[k].lsq, tbl[k].tag, tbl[k].rob, tbl[k].val));
            drive(0, 4'h2, 1, 0, 32'hFFFF, 32'h1111, 32'h2222, 5, 5);
            tick();
            check({tbl[k].name, "_idle"}, pack(1, 0, 0, 0, 0, 0));
        end

        for (int k = 1; k <= 3; k++) begin
            drive(1, 4'h2, 1, 0, k, 32'h10, 0, k[5:0], 6'(20 + k));
            tick();
            check($sformatf("b2b_%0d", k), pack(1, 1, 0, k[5:0], 6'(20 + k), 32'h10 + k));
        end
        drive(1, 4'h6, 1, 1, 8, 32'h100, 0, 0, 30);
        tick();
        check("b2b_lsq", pack(1, 1, 1, 0, 30, 32'h108));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("b2b_drain", pack(1, 0, 0, 0, 0, 0));

        drive(1, 4'h2, 0, 0, 0, 40, 2, 7, 7);
        tick();
        #2;
        reset = 0;
        #1;
        check("async_reset", pack(0, 0, 0, 0, 0, 0));
        tick();
        check("held_in_reset", pack(0, 0, 0, 0, 0, 0));
        reset = 1;
        drive(0, 4'h2, 0, 0, 0, 40, 2, 7, 7);
        tick();
        check("no_wakeup_after_reset", pack(1, 0, 0, 0, 0, 0));

        for (int n = 0; n < 400; n++) begin
            we = ($urandom_range(3) != 0);
            l = ($urandom_range(3) == 0);
            s = $urandom_range(1);
            c = 4'($urandom_range(15));
            t = ($urandom_range(7) == 0) ? 6'd0 : 6'($urandom);
            rb = 6'($urandom);
            i = ($urandom_range(1) != 0) ? 32'($urandom_range(63)) : $urandom;
            a = $urandom;
            r2 = ($urandom_range(1) != 0) ? 32'($urandom_range(63)) : $urandom;
            if ($urandom_range(7) == 0) a = 32'h8000_0000;
            drive(we, c, s, l, i, a, r2, t, rb);
            bb = s ? i : r2;
            v = l ? a + bb : (t == 0 ? 32'd0 : ref_alu(c, a, bb));
            tick();
            check($sformatf("rand_%0d_op%0d", n, c), pack(1, we, l, t, rb, v));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
